// File: rtl/pb_wire_decoder.sv
// Protobuf wire-format parser: one record per field, with delimited payload bytes
// forwarded combinationally on a separate stream.
module pb_wire_decoder #(
    parameter int unsigned MAX_VARINT_BYTES = 10,
    parameter int unsigned MAX_KEY_BYTES    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [28:0] out_field_num,
    output logic [2:0]  out_wire_type,
    output logic [63:0] out_value,
    output logic        out_last,
    output logic        pld_valid,
    input  logic        pld_ready,
    output logic [7:0]  pld_data,
    output logic        pld_last,
    output logic        pld_msg_last,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_KEY, S_VARINT, S_FIXED, S_EMIT, S_PAYLOAD, S_ERROR
    } state_t;

    localparam logic [1:0] E_BAD_WT   = 2'd1;
    localparam logic [1:0] E_OVERFLOW = 2'd2;
    localparam logic [1:0] E_TRUNC    = 2'd3;

    state_t      state, state_nxt;
    logic [1:0]  code_nxt, err_code_q;
    logic [31:0] key_acc;
    logic [63:0] acc, cnt;
    logic [3:0]  n, fix_len;
    logic [28:0] field_q;
    logic [2:0]  wt_q;
    logic        last_q;

    logic        in_fire, more;
    logic [6:0]  grp;
    logic [5:0]  shamt;
    logic [31:0] key_full;
    logic [63:0] val_full;
    logic [2:0]  key_wt;
    logic [28:0] key_field;
    logic        bad_key;

    assign in_fire   = in_valid && in_ready;
    assign more      = in_data[7];
    assign grp       = in_data[6:0];
    assign shamt     = 6'({2'b00, n} * 6'd7);
    assign key_full  = key_acc | ({25'd0, grp} << shamt);
    assign val_full  = acc | ({57'd0, grp} << shamt);
    assign key_wt    = key_full[2:0];
    assign key_field = key_full[31:3];
    assign bad_key   = (key_field == '0) || (key_wt == 3'd3) || (key_wt == 3'd4)
                     || (key_wt == 3'd6) || (key_wt == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_KEY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = err_code_q;
        unique case (state)
            S_KEY: if (in_fire) begin
                if (!more) begin
                    if (bad_key) begin
                        state_nxt = S_ERROR; code_nxt = E_BAD_WT;
                    end else if (in_last) begin
                        state_nxt = S_ERROR; code_nxt = E_TRUNC;
                    end else if (key_wt == 3'd1 || key_wt == 3'd5) begin
                        state_nxt = S_FIXED;
                    end else begin
                        state_nxt = S_VARINT;
                    end
                end else if (32'(n) == MAX_KEY_BYTES - 1) begin
                    state_nxt = S_ERROR; code_nxt = E_OVERFLOW;
                end else if (in_last) begin
                    state_nxt = S_ERROR; code_nxt = E_TRUNC;
                end
            end
            S_VARINT: if (in_fire) begin
                // Final allowed byte may only carry bit 63.
                if (32'(n) == MAX_VARINT_BYTES - 1 && (more || in_data[6:1] != '0)) begin
                    state_nxt = S_ERROR; code_nxt = E_OVERFLOW;
                end else if (!more) begin
                    if (in_last && wt_q == 3'd2 && val_full != '0) begin
                        state_nxt = S_ERROR; code_nxt = E_TRUNC;
                    end else begin
                        state_nxt = S_EMIT;
                    end
                end else if (in_last) begin
                    state_nxt = S_ERROR; code_nxt = E_TRUNC;
                end
            end
            S_FIXED: if (in_fire) begin
                if (n == fix_len - 4'd1) begin
                    state_nxt = S_EMIT;
                end else if (in_last) begin
                    state_nxt = S_ERROR; code_nxt = E_TRUNC;
                end
            end
            S_EMIT: if (out_ready) begin
                state_nxt = (wt_q == 3'd2 && acc != '0) ? S_PAYLOAD : S_KEY;
            end
            S_PAYLOAD: if (in_fire) begin
                if (cnt == 64'd1) begin
                    state_nxt = S_KEY;
                end else if (in_last) begin
                    state_nxt = S_ERROR; code_nxt = E_TRUNC;
                end
            end
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_KEY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_acc    <= '0;
            acc        <= '0;
            cnt        <= '0;
            n          <= '0;
            fix_len    <= '0;
            field_q    <= '0;
            wt_q       <= '0;
            last_q     <= 1'b0;
            err_code_q <= '0;
        end else begin
            if (state != S_ERROR && state_nxt == S_ERROR) err_code_q <= code_nxt;
            unique case (state)
                S_KEY: if (in_fire) begin
                    if (more) begin
                        key_acc <= key_full;
                        n       <= n + 4'd1;
                    end else begin
                        field_q <= key_field;
                        wt_q    <= key_wt;
                        fix_len <= (key_wt == 3'd1) ? 4'd8 : 4'd4;
                        key_acc <= '0;
                        acc     <= '0;
                        n       <= '0;
                    end
                end
                S_VARINT: if (in_fire) begin
                    acc <= val_full;
                    n   <= more ? n + 4'd1 : '0;
                    if (!more) last_q <= in_last;
                end
                S_FIXED: if (in_fire) begin
                    acc[{n[2:0], 3'b000} +: 8] <= in_data;
                    if (n == fix_len - 4'd1) begin
                        n      <= '0;
                        last_q <= in_last;
                    end else begin
                        n <= n + 4'd1;
                    end
                end
                S_EMIT:    if (out_ready) cnt <= acc;
                S_PAYLOAD: if (in_fire) cnt <= cnt - 64'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready      = 1'b1;
        out_valid     = 1'b0;
        out_field_num = '0;
        out_wire_type = '0;
        out_value     = '0;
        out_last      = 1'b0;
        pld_valid     = 1'b0;
        pld_data      = '0;
        pld_last      = 1'b0;
        pld_msg_last  = 1'b0;
        err           = 1'b0;
        err_code      = '0;
        unique case (state)
            S_EMIT: begin
                in_ready      = 1'b0;
                out_valid     = 1'b1;
                out_field_num = field_q;
                out_wire_type = wt_q;
                out_value     = acc;
                out_last      = last_q;
            end
            S_PAYLOAD: begin
                in_ready     = pld_ready;
                pld_valid    = in_valid;
                pld_data     = in_data;
                pld_last     = in_valid && (cnt == 64'd1);
                pld_msg_last = in_valid && (cnt == 64'd1) && in_last;
            end
            S_ERROR: begin
                err      = 1'b1;
                err_code = err_code_q;
            end
            default: ;
        endcase
    end

endmodule
